// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// sync_fifo_pkg : shared mode constants and parameter helpers for the FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

   localparam int MODE_STALL     = 0;
   localparam int MODE_OVERWRITE = 1;

   function automatic int ptr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic bit is_pow2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// sync_fifo_mem : DEPTH x DATA_W simple dual-port array, sync write, sync read
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Only the output register is reset; the array contents are left as-is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// sync_fifo_param : single-clock FIFO, stall or overwrite-oldest on overflow.
// Optional sticky error flags with `define SYNC_FIFO_ERR_EN. Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 16,
   parameter int AF_TH     = DEPTH - 2,
   parameter int OVERWRITE = 0
) (
   input  logic                        Write_Clk,
   input  logic                        rst_n,
   input  logic                        Write_En,
   input  logic [DATA_W-1:0]           Write_Data,
   input  logic                        Read_En,
   output logic [DATA_W-1:0]           Read_Data,
   output logic                        Read_Valid,
   output logic                        Full_Flag,
   output logic                        Empty_Flag,
   output logic                        Almost_Full,
   output logic [ptr_width(DEPTH):0]   Level
`ifdef SYNC_FIFO_ERR_EN
   ,
   input  logic                        Err_Clr,
   output logic                        Overflow_Err,
   output logic                        Underflow_Err
`endif
);

   localparam int PW  = ptr_width(DEPTH);
   localparam int LW  = PW + 1;
   localparam bit OVW = (OVERWRITE == MODE_OVERWRITE);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end
   if ((OVERWRITE != MODE_STALL) && (OVERWRITE != MODE_OVERWRITE)) begin : g_bad_mode
      $error("sync_fifo_param: OVERWRITE must be 0 or 1");
   end
   if ((AF_TH < 1) || (AF_TH > DEPTH)) begin : g_bad_af
      $error("sync_fifo_param: AF_TH must be in 1..DEPTH");
   end

   logic [PW-1:0] wp, rp;
   logic [LW-1:0] level_nxt;
   logic          rd_ok, wr_ok, ovw_drop;

   // Full/empty come from the registered flags, which always track Level.
   assign rd_ok    = Read_En && !Empty_Flag;
   assign wr_ok    = Write_En && (!Full_Flag || rd_ok || OVW);
   assign ovw_drop = wr_ok && Full_Flag && !rd_ok;

   always_comb begin
      level_nxt = Level;
      if (wr_ok && !rd_ok && !ovw_drop) level_nxt = Level + 1'b1;
      else if (rd_ok && !wr_ok)         level_nxt = Level - 1'b1;
   end

   always_ff @(posedge Write_Clk or negedge rst_n) begin
      if (!rst_n) begin
         wp          <= '0;
         rp          <= '0;
         Level       <= '0;
         Full_Flag   <= 1'b0;
         Empty_Flag  <= 1'b1;
         Almost_Full <= 1'b0;
         Read_Valid  <= 1'b0;
      end else begin
         if (wr_ok)             wp <= wp + 1'b1;
         if (rd_ok || ovw_drop) rp <= rp + 1'b1;
         Level       <= level_nxt;
         Full_Flag   <= (level_nxt == LW'(DEPTH));
         Empty_Flag  <= (level_nxt == '0);
         Almost_Full <= (level_nxt >= LW'(AF_TH));
         Read_Valid  <= rd_ok;
      end
   end

   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (PW)
   ) u_mem (
      .clk     (Write_Clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok),
      .wr_addr (wp),
      .wr_data (Write_Data),
      .rd_en   (rd_ok),
      .rd_addr (rp),
      .rd_data (Read_Data)
   );

`ifdef SYNC_FIFO_ERR_EN
   logic stall_drop;
   assign stall_drop = Write_En && !wr_ok;

   // A set in the same cycle as Err_Clr wins.
   always_ff @(posedge Write_Clk or negedge rst_n) begin
      if (!rst_n) begin
         Overflow_Err  <= 1'b0;
         Underflow_Err <= 1'b0;
      end else begin
         if (stall_drop || ovw_drop) Overflow_Err <= 1'b1;
         else if (Err_Clr)           Overflow_Err <= 1'b0;
         if (Read_En && Empty_Flag)  Underflow_Err <= 1'b1;
         else if (Err_Clr)           Underflow_Err <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// tb_sync_fifo_param : directed checks on DEPTH=4 stall and overwrite FIFOs
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic        st_we = 0, st_re = 0;
   logic [15:0] st_wd = '0, st_rd;
   logic        st_rv, st_full, st_empty, st_af;
   logic [2:0]  st_lvl;

   logic        ov_we = 0, ov_re = 0;
   logic [15:0] ov_wd = '0, ov_rd;
   logic        ov_rv, ov_full, ov_empty, ov_af;
   logic [2:0]  ov_lvl;

`ifdef SYNC_FIFO_ERR_EN
   logic st_clr = 0, st_ovf, st_unf;
   logic ov_clr = 0, ov_ovf, ov_unf;
`endif

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_W(16), .DEPTH(4), .AF_TH(2), .OVERWRITE(0)) u_stall (
      .Write_Clk(clk), .rst_n(rst_n), .Write_En(st_we), .Write_Data(st_wd),
      .Read_En(st_re), .Read_Data(st_rd), .Read_Valid(st_rv), .Full_Flag(st_full),
      .Empty_Flag(st_empty), .Almost_Full(st_af), .Level(st_lvl)
`ifdef SYNC_FIFO_ERR_EN
      , .Err_Clr(st_clr), .Overflow_Err(st_ovf), .Underflow_Err(st_unf)
`endif
   );

   sync_fifo_param #(.DATA_W(16), .DEPTH(4), .AF_TH(2), .OVERWRITE(1)) u_ovw (
      .Write_Clk(clk), .rst_n(rst_n), .Write_En(ov_we), .Write_Data(ov_wd),
      .Read_En(ov_re), .Read_Data(ov_rd), .Read_Valid(ov_rv), .Full_Flag(ov_full),
      .Empty_Flag(ov_empty), .Almost_Full(ov_af), .Level(ov_lvl)
`ifdef SYNC_FIFO_ERR_EN
      , .Err_Clr(ov_clr), .Overflow_Err(ov_ovf), .Underflow_Err(ov_unf)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (st_empty !== 1'b1) begin n_fail++; $display("FAIL reset st_empty got %b want 1", st_empty); end
      n_checks++; if (st_lvl !== 3'd0) begin n_fail++; $display("FAIL reset st_lvl got %0d want 0", st_lvl); end
      n_checks++; if (st_rv !== 1'b0) begin n_fail++; $display("FAIL reset st_rv got %b want 0", st_rv); end
      n_checks++; if (st_full !== 1'b0) begin n_fail++; $display("FAIL reset st_full got %b want 0", st_full); end
      n_checks++; if (st_af !== 1'b0) begin n_fail++; $display("FAIL reset st_af got %b want 0", st_af); end
      n_checks++; if (st_rd !== 16'h0) begin n_fail++; $display("FAIL reset st_rd got %h want 0000", st_rd); end
      n_checks++; if (ov_empty !== 1'b1 || ov_lvl !== 3'd0 || ov_rv !== 1'b0 || ov_full !== 1'b0)
         begin n_fail++; $display("FAIL reset ovw e/l/v/f got %b/%0d/%b/%b want 1/0/0/0", ov_empty, ov_lvl, ov_rv, ov_full); end
`ifdef SYNC_FIFO_ERR_EN
      n_checks++; if (st_ovf !== 1'b0 || st_unf !== 1'b0) begin n_fail++; $display("FAIL reset err got %b%b want 00", st_ovf, st_unf); end
`endif
   endtask

   task automatic test_stall_fill();
      st_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         st_wd = 16'hA001 + 16'(i);
         tick();
         n_checks++; if (st_lvl !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin n_fail++; $display("FAIL stall_fill lvl[%0d] got %0d", i, st_lvl); end
         n_checks++; if (st_full !== (i >= 3)) begin n_fail++; $display("FAIL stall_fill full[%0d] got %b", i, st_full); end
         n_checks++; if (st_af !== (i >= 1)) begin n_fail++; $display("FAIL stall_fill af[%0d] got %b", i, st_af); end
      end
      st_we = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
      n_checks++; if (st_ovf !== 1'b1) begin n_fail++; $display("FAIL stall_fill ovf got %b want 1", st_ovf); end
`endif
      st_re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (st_rv !== 1'b1 || st_rd !== 16'hA001 + 16'(i))
            begin n_fail++; $display("FAIL stall_read[%0d] got v=%b %h want v=1 %h", i, st_rv, st_rd, 16'hA001 + 16'(i)); end
         n_checks++; if (st_lvl !== 3'(3 - i)) begin n_fail++; $display("FAIL stall_read lvl[%0d] got %0d want %0d", i, st_lvl, 3 - i); end
      end
      st_re = 1'b0;
      tick();
      n_checks++; if (st_rv !== 1'b0 || st_rd !== 16'hA004 || st_empty !== 1'b1)
         begin n_fail++; $display("FAIL stall_idle got v=%b %h e=%b want v=0 a004 e=1", st_rv, st_rd, st_empty); end
   endtask

   task automatic test_overwrite();
      ov_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ov_wd = 16'hA001 + 16'(i);
         tick();
      end
      ov_we = 1'b0;
      n_checks++; if (ov_lvl !== 3'd4 || ov_full !== 1'b1 || ov_rv !== 1'b0)
         begin n_fail++; $display("FAIL ovw_fill got l=%0d f=%b v=%b want 4/1/0", ov_lvl, ov_full, ov_rv); end
`ifdef SYNC_FIFO_ERR_EN
      n_checks++; if (ov_ovf !== 1'b1) begin n_fail++; $display("FAIL ovw ovf got %b want 1", ov_ovf); end
`endif
      ov_re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (ov_rv !== 1'b1 || ov_rd !== 16'hA002 + 16'(i))
            begin n_fail++; $display("FAIL ovw_read[%0d] got v=%b %h want v=1 %h", i, ov_rv, ov_rd, 16'hA002 + 16'(i)); end
         n_checks++; if (ov_lvl !== 3'(3 - i)) begin n_fail++; $display("FAIL ovw_read lvl[%0d] got %0d want %0d", i, ov_lvl, 3 - i); end
      end
      ov_re = 1'b0;
      tick();
      n_checks++; if (ov_empty !== 1'b1 || ov_rv !== 1'b0) begin n_fail++; $display("FAIL ovw_idle got e=%b v=%b want 1/0", ov_empty, ov_rv); end
   endtask

`ifdef SYNC_FIFO_ERR_EN
   task automatic test_err_clear();
      st_clr = 1'b1; ov_clr = 1'b1;
      tick();
      st_clr = 1'b0; ov_clr = 1'b0;
      n_checks++; if (st_ovf !== 1'b0 || ov_ovf !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b%b want 00", st_ovf, ov_ovf); end
   endtask
`endif

   task automatic test_full_simul();
      logic [15:0] exp [4];
      exp[0] = 16'hC002; exp[1] = 16'hC003; exp[2] = 16'hC004; exp[3] = 16'hBEEF;
      st_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         st_wd = 16'hC001 + 16'(i);
         tick();
      end
      st_wd = 16'hBEEF; st_re = 1'b1;
      tick();
      st_we = 1'b0;
      n_checks++; if (st_rv !== 1'b1 || st_rd !== 16'hC001) begin n_fail++; $display("FAIL full_simul got v=%b %h want v=1 c001", st_rv, st_rd); end
      n_checks++; if (st_lvl !== 3'd4 || st_full !== 1'b1) begin n_fail++; $display("FAIL full_simul got l=%0d f=%b want 4/1", st_lvl, st_full); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (st_rv !== 1'b1 || st_rd !== exp[i]) begin n_fail++; $display("FAIL full_drain[%0d] got v=%b %h want v=1 %h", i, st_rv, st_rd, exp[i]); end
      end
      st_re = 1'b0;
      tick();
   endtask

   task automatic test_empty_rw();
      st_we = 1'b1; st_re = 1'b1; st_wd = 16'h1234;
      tick();
      st_we = 1'b0;
      n_checks++; if (st_rv !== 1'b0 || st_lvl !== 3'd1 || st_empty !== 1'b0)
         begin n_fail++; $display("FAIL empty_rw got v=%b l=%0d e=%b want 0/1/0", st_rv, st_lvl, st_empty); end
`ifdef SYNC_FIFO_ERR_EN
      n_checks++; if (st_unf !== 1'b1) begin n_fail++; $display("FAIL empty_rw unf got %b want 1", st_unf); end
`endif
      tick();
      st_re = 1'b0;
      n_checks++; if (st_rv !== 1'b1 || st_rd !== 16'h1234 || st_lvl !== 3'd0)
         begin n_fail++; $display("FAIL empty_rw read got v=%b %h l=%0d want 1/1234/0", st_rv, st_rd, st_lvl); end
      tick();
   endtask

   task automatic test_wrap();
      logic [15:0] q [$];
      logic [15:0] want;
      int next_w = 0, n_rd = 0;
      bit exp_rd, exp_wr;
      for (int c = 0; c < 200 && n_rd < 20; c++) begin
         st_we = (next_w < 20) && (c % 3 != 2);
         st_re = (c % 2 == 1);
         st_wd = 16'hD000 + 16'(next_w);
         exp_rd = st_re && (q.size() != 0);
         exp_wr = st_we && ((q.size() < 4) || exp_rd);
         tick();
         n_checks++; if (st_rv !== exp_rd) begin n_fail++; $display("FAIL wrap rv[c%0d] got %b want %b", c, st_rv, exp_rd); end
         if (exp_rd) begin
            want = q.pop_front();
            n_rd++;
            n_checks++; if (st_rd !== want) begin n_fail++; $display("FAIL wrap data[c%0d] got %h want %h", c, st_rd, want); end
         end
         if (exp_wr) begin
            q.push_back(st_wd);
            next_w++;
         end
         n_checks++; if (st_lvl !== 3'(q.size())) begin n_fail++; $display("FAIL wrap lvl[c%0d] got %0d want %0d", c, st_lvl, q.size()); end
      end
      st_we = 1'b0; st_re = 1'b0;
      n_checks++; if (n_rd != 20) begin n_fail++; $display("FAIL wrap timeout read %0d words want 20", n_rd); end
   endtask

   task automatic test_reset_mid();
      st_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         st_wd = 16'hE000 + 16'(i);
         tick();
      end
      st_we = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (st_lvl !== 3'd0 || st_empty !== 1'b1) begin n_fail++; $display("FAIL reset_mid got l=%0d e=%b want 0/1", st_lvl, st_empty); end
      tick(); tick();
      rst_n = 1'b1;
      st_re = 1'b1;
      tick();
      st_re = 1'b0;
      n_checks++; if (st_rv !== 1'b0 || st_lvl !== 3'd0 || st_empty !== 1'b1)
         begin n_fail++; $display("FAIL reset_after got v=%b l=%0d e=%b want 0/0/1", st_rv, st_lvl, st_empty); end
   endtask

   initial begin
      test_reset();
      test_stall_fill();
      test_overwrite();
`ifdef SYNC_FIFO_ERR_EN
      test_err_clear();
`endif
      test_full_simul();
      test_empty_rw();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
